// File: rtl/game_actor_mover.sv
// Maze sprite mover: fractional-speed stepping, relative/absolute steering, tunnel wrap, animation.
// Outputs registered on clk60 (tiles combinational); no backpressure, one decision per frame.
module game_actor_mover #(
    parameter int         COORD_W       = 9,
    parameter int         TILE_SHIFT    = 3,
    parameter int         CENTER        = 3,
    parameter int         Y_TILE_OFFSET = 3,
    parameter int         MAZE_W_PX     = 224,
    parameter int         START_X       = 119,
    parameter int         START_Y       = 227,
    parameter logic [1:0] START_DIR     = 2'b00,
    parameter int         SPEED_W       = 8,
    parameter int         ABS_STEER     = 0
) (
    input  logic                          clk60,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          pause,
    input  logic                          btn_left,
    input  logic                          btn_right,
    input  logic                          btn_uturn,
    input  logic                          req_valid,
    input  logic [1:0]                    req_dir,
    input  logic [SPEED_W-1:0]            speed,
    input  logic [7:0]                    tile_info,
    output logic [COORD_W-1:0]            xloc,
    output logic [COORD_W-1:0]            yloc,
    output logic [COORD_W-TILE_SHIFT-1:0] xtile,
    output logic [COORD_W-TILE_SHIFT-1:0] ytile,
    output logic [1:0]                    dir,
    output logic [1:0]                    anim_cycle,
    output logic                          moving,
    output logic [1:0]                    state
);
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10} state_e;

    localparam logic [COORD_W-1:0]    L_START_X = COORD_W'(START_X);
    localparam logic [COORD_W-1:0]    L_START_Y = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0]    L_X_MAX   = COORD_W'(MAZE_W_PX - 1);
    localparam logic [TILE_SHIFT-1:0] L_CENTER  = TILE_SHIFT'(CENTER);
    localparam logic [COORD_W-TILE_SHIFT-1:0] L_Y_OFS = (COORD_W-TILE_SHIFT)'(Y_TILE_OFFSET);

    state_e               r_state, w_state_nxt;
    logic [COORD_W-1:0]   r_x, r_y, w_x_nxt, w_y_nxt;
    logic [1:0]           r_dir, r_queue, r_anim, w_queue_nxt, w_dir_nxt;
    logic                 r_phase, r_moving;
    logic [SPEED_W-1:0]   r_acc;
    logic [2:0]           r_btn_sync;
    logic [1:0]           r_sr_l, r_sr_r, r_sr_u;
    logic [SPEED_W:0]     w_sum;
    logic                 w_run, w_active, w_step, w_center, w_rev, w_perp, w_move;
    logic                 w_edge_l, w_edge_r, w_edge_u;
    logic [1:0]           w_tile_q, w_tile_d;

    function automatic logic blocked(input logic [1:0] cls);
        return (cls == 2'b00) || (cls == 2'b11);
    endfunction

    function automatic logic [1:0] rot_ccw(input logic [1:0] d);
        case (d)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rot_cw(input logic [1:0] d);
        case (d)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = start ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = pause ? S_PAUSE : S_RUN;
            S_PAUSE: w_state_nxt = pause ? S_PAUSE : S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_run    = (r_state == S_RUN);
    assign w_active = (r_state == S_RUN) || (r_state == S_PAUSE);

    // Buttons pass a sync flop before the edge detector
    assign w_edge_l = (ABS_STEER == 0) && (r_sr_l == 2'b01);
    assign w_edge_r = (ABS_STEER == 0) && (r_sr_r == 2'b01);
    assign w_edge_u = (ABS_STEER == 0) && (r_sr_u == 2'b01);

    always_comb begin
        w_queue_nxt = r_queue;
        if (!w_active)
            w_queue_nxt = START_DIR;
        else if (ABS_STEER != 0) begin
            if (req_valid)
                w_queue_nxt = req_dir;
        end else if (w_edge_l)
            w_queue_nxt = rot_ccw(r_dir);
        else if (w_edge_r)
            w_queue_nxt = rot_cw(r_dir);
        else if (w_edge_u)
            w_queue_nxt = ~r_dir;
    end

    assign w_sum     = {1'b0, r_acc} + {1'b0, speed};
    assign w_step    = w_sum[SPEED_W];
    assign w_center  = (r_x[TILE_SHIFT-1:0] == L_CENTER) && (r_y[TILE_SHIFT-1:0] == L_CENTER);
    assign w_tile_q  = tile_info[{r_queue, 1'b0} +: 2];
    assign w_rev     = (r_queue == ~r_dir);
    assign w_perp    = !w_rev && (r_queue != r_dir) && w_center && !blocked(w_tile_q);
    assign w_dir_nxt = (w_rev || w_perp) ? r_queue : r_dir;
    assign w_tile_d  = tile_info[{w_dir_nxt, 1'b0} +: 2];
    // A perpendicular turn consumes the frame; reversals move immediately
    assign w_move    = w_run && w_step && !w_perp && !(w_center && blocked(w_tile_d));

    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        case (w_dir_nxt)
            2'b00:   w_x_nxt = (r_x == L_X_MAX) ? '0 : r_x + 1'b1;
            2'b11:   w_x_nxt = (r_x == '0) ? L_X_MAX : r_x - 1'b1;
            2'b01:   w_y_nxt = r_y - 1'b1;
            default: w_y_nxt = r_y + 1'b1;
        endcase
    end

    always_ff @(posedge clk60 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_x        <= L_START_X;
            r_y        <= L_START_Y;
            r_dir      <= START_DIR;
            r_queue    <= START_DIR;
            r_anim     <= 2'd1;
            r_phase    <= 1'b0;
            r_moving   <= 1'b0;
            r_acc      <= '0;
            r_btn_sync <= '0;
            r_sr_l     <= '0;
            r_sr_r     <= '0;
            r_sr_u     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_btn_sync <= {btn_uturn, btn_right, btn_left};
            r_sr_l     <= {r_sr_l[0], r_btn_sync[0]};
            r_sr_r     <= {r_sr_r[0], r_btn_sync[1]};
            r_sr_u     <= {r_sr_u[0], r_btn_sync[2]};
            r_queue    <= w_queue_nxt;
            if (w_run) begin
                r_acc    <= w_sum[SPEED_W-1:0];
                r_dir    <= w_dir_nxt;
                r_moving <= w_move;
                if (w_move) begin
                    r_x     <= w_x_nxt;
                    r_y     <= w_y_nxt;
                    r_phase <= ~r_phase;
                    if (r_phase)
                        r_anim <= r_anim + 2'd1;
                end else if (r_anim == 2'd0) begin
                    r_anim <= 2'd1;
                end
            end else if (r_state == S_PAUSE) begin
                r_moving <= 1'b0;
            end else begin
                r_x      <= L_START_X;
                r_y      <= L_START_Y;
                r_dir    <= START_DIR;
                r_acc    <= '0;
                r_anim   <= 2'd1;
                r_phase  <= 1'b0;
                r_moving <= 1'b0;
            end
        end
    end

    assign xloc       = r_x;
    assign yloc       = r_y;
    assign xtile      = r_x[COORD_W-1:TILE_SHIFT];
    assign ytile      = r_y[COORD_W-1:TILE_SHIFT] - L_Y_OFS;
    assign dir        = r_dir;
    assign anim_cycle = r_anim;
    assign moving     = r_moving;
    assign state      = r_state;
endmodule

// File: tb/tb_game_actor_mover.sv
// Scoreboard bench for game_actor_mover: relative-steering and absolute-steering instances.
module tb_game_actor_mover;
    logic       clk60 = 1'b0;
    logic       rst_n, rst_n_b, start, start_b, pause;
    logic       btn_left, btn_right, btn_uturn, req_valid;
    logic [1:0] req_dir;
    logic [7:0] speed, tile_info, tile_info_b;

    logic [8:0] xloc_a, yloc_a, xloc_b, yloc_b;
    logic [5:0] xtile_a, ytile_a, xtile_b, ytile_b;
    logic [1:0] dir_a, anim_a, state_a, dir_b, anim_b, state_b;
    logic       moving_a, moving_b;

    always #5 clk60 = ~clk60;

    game_actor_mover u_rel (
        .clk60(clk60), .rst_n(rst_n), .start(start), .pause(pause),
        .btn_left(btn_left), .btn_right(btn_right), .btn_uturn(btn_uturn),
        .req_valid(req_valid), .req_dir(req_dir), .speed(speed), .tile_info(tile_info),
        .xloc(xloc_a), .yloc(yloc_a), .xtile(xtile_a), .ytile(ytile_a),
        .dir(dir_a), .anim_cycle(anim_a), .moving(moving_a), .state(state_a)
    );

    game_actor_mover #(.ABS_STEER(1)) u_abs (
        .clk60(clk60), .rst_n(rst_n_b), .start(start_b), .pause(pause),
        .btn_left(btn_left), .btn_right(btn_right), .btn_uturn(btn_uturn),
        .req_valid(req_valid), .req_dir(req_dir), .speed(speed), .tile_info(tile_info_b),
        .xloc(xloc_b), .yloc(yloc_b), .xtile(xtile_b), .ytile(ytile_b),
        .dir(dir_b), .anim_cycle(anim_b), .moving(moving_b), .state(state_b)
    );

    // mask bits: 0 state, 1 x, 2 y, 3 dir, 4 anim, 5 moving, 6 tiles
    localparam logic [6:0] M_ALL    = 7'h7F;
    localparam logic [6:0] M_NOANIM = 7'h6F;

    typedef struct {
        bit         b;
        logic [6:0] m;
        logic [1:0] st;
        logic [8:0] x;
        logic [8:0] y;
        logic [1:0] d;
        logic [1:0] a;
        logic       mv;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cmp(input string nm, input string f, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, f, act, req);
        end
    endtask

    always @(negedge clk60) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [8:0] ax, ay;
            logic [5:0] axt, ayt;
            logic [1:0] ad, aa, ast;
            logic       amv;
            e = sb.pop_front();
            if (e.b) begin
                ax = xloc_b; ay = yloc_b; axt = xtile_b; ayt = ytile_b;
                ad = dir_b; aa = anim_b; ast = state_b; amv = moving_b;
            end else begin
                ax = xloc_a; ay = yloc_a; axt = xtile_a; ayt = ytile_a;
                ad = dir_a; aa = anim_a; ast = state_a; amv = moving_a;
            end
            if (e.m[0]) cmp(e.nm, "state", int'(ast), int'(e.st));
            if (e.m[1]) cmp(e.nm, "xloc", int'(ax), int'(e.x));
            if (e.m[2]) cmp(e.nm, "yloc", int'(ay), int'(e.y));
            if (e.m[3]) cmp(e.nm, "dir", int'(ad), int'(e.d));
            if (e.m[4]) cmp(e.nm, "anim", int'(aa), int'(e.a));
            if (e.m[5]) cmp(e.nm, "moving", int'(amv), int'(e.mv));
            if (e.m[6]) begin
                cmp(e.nm, "xtile", int'(axt), int'(e.x >> 3));
                cmp(e.nm, "ytile", int'(ayt), ((int'(e.y) >> 3) - 3) & 63);
            end
        end
    end

    task automatic push(input bit b, input logic [6:0] m, input logic [1:0] st,
                        input logic [8:0] x, input logic [8:0] y, input logic [1:0] d,
                        input logic [1:0] a, input logic mv, input string nm);
        exp_t e;
        e.b = b; e.m = m; e.st = st; e.x = x; e.y = y; e.d = d; e.a = a; e.mv = mv; e.nm = nm;
        sb.push_back(e);
    endtask

    // Advance one frame; the expectation describes outputs after this edge
    task automatic tick(input bit b, input logic [6:0] m, input logic [1:0] st,
                        input logic [8:0] x, input logic [8:0] y, input logic [1:0] d,
                        input logic [1:0] a, input logic mv, input string nm);
        @(posedge clk60);
        #1;
        push(b, m, st, x, y, d, a, mv, nm);
    endtask

    // Reset asserted between edges; spawn values must appear before any further edge
    task automatic rst_async(input bit b, input string nm);
        @(posedge clk60);
        #2;
        if (b) rst_n_b = 1'b0;
        else   rst_n   = 1'b0;
        push(b, M_ALL, 2'd0, 9'd119, 9'd227, 2'd0, 2'd1, 1'b0, nm);
    endtask

    initial begin
        rst_n = 1'b0; rst_n_b = 1'b0; start = 1'b0; start_b = 1'b0; pause = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_uturn = 1'b0;
        req_valid = 1'b0; req_dir = 2'b00;
        speed = 8'd255; tile_info = 8'h55; tile_info_b = 8'h55;

        tick(0, M_ALL, 2'd0, 9'd119, 9'd227, 2'd0, 2'd1, 1'b0, "reset");
        rst_n = 1'b1; start = 1'b1;
        tick(0, M_ALL, 2'd1, 9'd119, 9'd227, 2'd0, 2'd1, 1'b0, "start");
        start = 1'b0;
        tick(0, M_ALL, 2'd1, 9'd119, 9'd227, 2'd0, 2'd1, 1'b0, "run_first_nocarry");
        // speed 255: one pixel per frame, through the right-hand tunnel
        for (int i = 1; i <= 105; i++)
            tick(0, M_ALL, 2'd1, 9'((119 + i) % 224), 9'd227, 2'd0, 2'((1 + i / 2) % 4), 1'b1, "run255");

        pause = 1'b1;
        tick(0, M_ALL, 2'd2, 9'd1, 9'd227, 2'd0, 2'd2, 1'b1, "pause_entry");
        btn_uturn = 1'b1;
        tick(0, M_ALL, 2'd2, 9'd1, 9'd227, 2'd0, 2'd2, 1'b0, "paused");
        btn_uturn = 1'b0;
        for (int i = 0; i < 9; i++)
            tick(0, M_ALL, 2'd2, 9'd1, 9'd227, 2'd0, 2'd2, 1'b0, "paused");
        pause = 1'b0;
        tick(0, M_ALL, 2'd1, 9'd1, 9'd227, 2'd0, 2'd2, 1'b0, "unpause");
        tick(0, M_ALL, 2'd1, 9'd0, 9'd227, 2'd3, 2'd2, 1'b1, "queued_uturn_move");
        tick(0, M_ALL, 2'd1, 9'd223, 9'd227, 2'd3, 2'd3, 1'b1, "wrap_left");

        speed = 8'd128;
        for (int t = 1; t <= 8; t++)
            tick(0, M_NOANIM, 2'd1, 9'(223 - (t + 1) / 2), 9'd227, 2'd3, 2'd0, 1'(t % 2), "speed128");
        speed = 8'd64;
        for (int t = 1; t <= 8; t++)
            tick(0, M_NOANIM, 2'd1, 9'(219 - (t + 2) / 4), 9'd227, 2'd3, 2'd0, 1'(t % 4 == 2), "speed64");

        rst_async(0, "rst_mid_move_rel");
        tick(0, M_ALL, 2'd0, 9'd119, 9'd227, 2'd0, 2'd1, 1'b0, "reset_hold");

        // Left press queued early; turn only at tile centre x=123
        rst_n = 1'b1; speed = 8'd255; start = 1'b1; btn_left = 1'b1;
        tick(0, M_ALL, 2'd1, 9'd119, 9'd227, 2'd0, 2'd1, 1'b0, "restart");
        start = 1'b0;
        tick(0, M_ALL, 2'd1, 9'd119, 9'd227, 2'd0, 2'd1, 1'b0, "restart_nocarry");
        btn_left = 1'b0;
        tick(0, M_ALL, 2'd1, 9'd120, 9'd227, 2'd0, 2'd1, 1'b1, "pre_turn");
        tick(0, M_ALL, 2'd1, 9'd121, 9'd227, 2'd0, 2'd2, 1'b1, "pre_turn");
        tick(0, M_ALL, 2'd1, 9'd122, 9'd227, 2'd0, 2'd2, 1'b1, "pre_turn");
        tick(0, M_ALL, 2'd1, 9'd123, 9'd227, 2'd0, 2'd3, 1'b1, "reach_centre");
        tick(0, M_ALL, 2'd1, 9'd123, 9'd227, 2'd1, 2'd3, 1'b0, "turn_at_centre");
        tick(0, M_ALL, 2'd1, 9'd123, 9'd226, 2'd1, 2'd3, 1'b1, "move_up");
        tile_info = 8'h51;
        for (int k = 1; k <= 7; k++)
            tick(0, M_ALL, 2'd1, 9'd123, 9'(226 - k), 2'd1, 2'((1 + (5 + k) / 2) % 4), 1'b1, "move_up");
        tick(0, M_ALL, 2'd1, 9'd123, 9'd219, 2'd1, 2'd3, 1'b0, "wall_hold");
        tick(0, M_ALL, 2'd1, 9'd123, 9'd219, 2'd1, 2'd3, 1'b0, "wall_hold");
        btn_uturn = 1'b1;
        tick(0, M_ALL, 2'd1, 9'd123, 9'd219, 2'd1, 2'd3, 1'b0, "wall_hold");
        btn_uturn = 1'b0;
        tick(0, M_ALL, 2'd1, 9'd123, 9'd219, 2'd1, 2'd3, 1'b0, "wall_hold");
        tick(0, M_ALL, 2'd1, 9'd123, 9'd219, 2'd1, 2'd3, 1'b0, "wall_hold");
        tick(0, M_ALL, 2'd1, 9'd123, 9'd220, 2'd2, 2'd3, 1'b1, "uturn_move");
        tick(0, M_ALL, 2'd1, 9'd123, 9'd221, 2'd2, 2'd0, 1'b1, "after_uturn");
        rst_async(0, "rst_mid_move_rel2");

        // Absolute steering: request into ghost house is refused, buttons ignored
        rst_n_b = 1'b1; start_b = 1'b1;
        tick(1, M_ALL, 2'd1, 9'd119, 9'd227, 2'd0, 2'd1, 1'b0, "abs_start");
        start_b = 1'b0; req_valid = 1'b1; req_dir = 2'b10; tile_info_b = 8'h75;
        tick(1, M_ALL, 2'd1, 9'd119, 9'd227, 2'd0, 2'd1, 1'b0, "abs_nocarry");
        req_valid = 1'b0; btn_left = 1'b1;
        tick(1, M_ALL, 2'd1, 9'd120, 9'd227, 2'd0, 2'd1, 1'b1, "abs_run");
        btn_left = 1'b0;
        tick(1, M_ALL, 2'd1, 9'd121, 9'd227, 2'd0, 2'd2, 1'b1, "abs_run");
        tick(1, M_ALL, 2'd1, 9'd122, 9'd227, 2'd0, 2'd2, 1'b1, "abs_run");
        tick(1, M_ALL, 2'd1, 9'd123, 9'd227, 2'd0, 2'd3, 1'b1, "abs_centre");
        tick(1, M_ALL, 2'd1, 9'd124, 9'd227, 2'd0, 2'd3, 1'b1, "abs_no_ghost_turn");
        tick(1, M_ALL, 2'd1, 9'd125, 9'd227, 2'd0, 2'd0, 1'b1, "abs_run");
        req_valid = 1'b1; req_dir = 2'b11;
        tick(1, M_ALL, 2'd1, 9'd126, 9'd227, 2'd0, 2'd0, 1'b1, "abs_req_rev");
        req_valid = 1'b0;
        tick(1, M_ALL, 2'd1, 9'd125, 9'd227, 2'd3, 2'd1, 1'b1, "abs_reverse");
        rst_async(1, "rst_mid_move_abs");

        @(negedge clk60);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/game_actor_mover.md
# game_actor_mover

Parametrised maze-actor movement engine, the successor to the fixed Pac-Man mover, driving any sprite (player or ghost) in the 60 Hz game domain. It adds programmable fractional speed, a choice of relative (left/right/U-turn) or absolute (direction request) steering, horizontal tunnel wrap-around, and generic tile and coordinate geometry. It consumes the 4-neighbour tile classes from the maze lookup and produces the sprite position, facing and animation frame for the renderer.

## Interface
- COORD_W, 9, pixel coordinate width for xloc/yloc
- TILE_SHIFT, 3, log2 of tile size in pixels (8 px tiles)
- CENTER, 3, in-tile pixel offset that counts as tile centre (x[TILE_SHIFT-1:0] and y[TILE_SHIFT-1:0] both equal CENTER)
- Y_TILE_OFFSET, 3, tile rows subtracted from ytile (HUD rows)
- MAZE_W_PX, 224, horizontal wrap width in pixels
- START_X, 119 / START_Y, 227 / START_DIR, 2'b00, spawn position and facing
- SPEED_W, 8, speed accumulator width
- ABS_STEER, 0, 0 = relative buttons, 1 = absolute req_dir
- clk60  in  1  60 Hz frame clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  leave IDLE
- pause  in  1  level; hold in PAUSE while high
- btn_left, btn_right, btn_uturn  in  1  relative steering (ABS_STEER=0), rising-edge detected
- req_valid  in  1 / req_dir  in  2  absolute steering request (ABS_STEER=1)
- speed  in  SPEED_W  pixel-step rate: steps per frame = speed / 2^SPEED_W
- tile_info  in  8  neighbour classes, tile_info[2d+1:2d] = tile in direction d
- xloc, yloc  out  COORD_W  sprite pixel position
- xtile, ytile  out  COORD_W-TILE_SHIFT  xloc>>TILE_SHIFT, (yloc>>TILE_SHIFT)-Y_TILE_OFFSET (combinational from registers)
- dir  out  2  facing; anim_cycle  out  2  mouth/leg frame; moving  out  1  stepped last cycle
- state  out  2  IDLE=00, RUN=01, PAUSE=10

## Operation
- Direction code: RIGHT=00, UP=01, DOWN=10, LEFT=11; reverse of d is ~d. Tile classes: 00 wall, 01 open, 10 pellet, 11 ghost house; "blocked" = 00 or 11.
- FSM: IDLE→RUN when start; RUN→PAUSE when pause; PAUSE→RUN when !pause. start ignored outside IDLE. Encoding 11 unreachable; decodes to IDLE.
- IDLE: xloc/yloc/dir forced to START_X/START_Y/START_DIR, acc=0, queue=START_DIR, anim_cycle=1.
- Steering queue (captured in RUN and PAUSE, cleared to dir in IDLE):
  - ABS_STEER=0: each button through a 2-bit shift register, edge = sr==2'b01. Priority left > right > uturn. left: queue = CCW(dir) (R→U→L→D→R); right: CW; uturn: ~dir.
  - ABS_STEER=1: req_valid → queue = req_dir. Button inputs ignored.
  - Otherwise queue holds.
- Step generation (RUN only): {carry, acc} = acc + speed; step = carry. acc frozen in IDLE/PAUSE. speed=0 never steps; speed=2^SPEED_W-1 steps on 255 of 256 frames (for width 8).
- Turn (RUN, every cycle, independent of step): queue==~dir → dir=queue immediately; else queue!=dir, at centre and tile_info[queue] not blocked → dir=queue. Otherwise dir holds.
- Move (RUN, step=1): no move on a cycle where a perpendicular turn is taken; no move when at centre and tile_info[dir] blocked; else move 1 px in new dir. Reverse turns move in the new direction the same cycle.
- Wrap: moving RIGHT from x=MAZE_W_PX-1 → x=0; LEFT from x=0 → MAZE_W_PX-1. y never wraps (walls guarantee bounds).
- Animation: 1-bit phase toggles on each pixel move; anim_cycle increments (mod 4) on moves where phase was 1. When not moving, anim_cycle 0 forced to 1; others hold.

## Timing
- All outputs registered on posedge clk60 except xtile/ytile. Reset (async, rst_n=0): state=IDLE, xloc=START_X, yloc=START_Y, dir=START_DIR, anim_cycle=1, moving=0, acc=0, queue=START_DIR, shift registers 0.
- rst_n assertion mid-move takes effect immediately, independent of clk60; release synchronous to next edge.
- Button high at edge N → edge detected after edge N+1 → queue updated edge N+2 → dir earliest edge N+3.
- start high at edge N → RUN after N; first possible move at edge N+1.
- PAUSE: position, dir, acc, anim frozen; queue still updates and is applied on return to RUN.

## Test plan
- Reset then start, speed=255, open corridor right: xloc 119→120→… one px per frame except one frame per 256; dir=00, anim_cycle 1,1,2,2,3,3,0,…
- speed=128: exactly one step every 2 frames; speed=64: every 4; pause 10 frames mid-run → xloc and acc unchanged, resumes same phase.
- At x=117 (not centre), press left with tile_info UP open: dir stays 00 until x=123 (centre), then dir=01 with no move that frame, then y decrements.
- Wall ahead (tile_info[1:0]=00) at centre: position holds, moving=0, anim_cycle stays non-zero; uturn → dir=11 and x decrements same frame.
- Tunnel: x=223 moving right, step → x=0; x=0 moving left → x=223.
- ABS_STEER=1, req_valid with req_dir=10 into ghost-house tile (11): no turn; buttons toggled → ignored; rst_n low mid-move → outputs at spawn values without a clock edge.
